// File: rtl/rx_pkt_fifo_ctrl_if.sv
// Bundles the loopback receive stream, the data FIFO write port and the status word.
// No latency of its own; master is the stream/FIFO side, slave is the controller.
// No backpressure on the stream; the FIFO side reports occupancy only.
interface rx_pkt_fifo_ctrl_if #(
    parameter int FIFO_AW = 9
);
    logic [63:0]      in_data;
    logic             in_valid;
    logic             in_eof;
    logic             cnt_clr;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_wr_en;
    logic [64:0]      fifo_din;
    logic [31:0]      status;

    modport master (
        output in_data, in_valid, in_eof, cnt_clr, fifo_count,
        input  fifo_wr_en, fifo_din, status
    );

    modport slave (
        input  in_data, in_valid, in_eof, cnt_clr, fifo_count,
        output fifo_wr_en, fifo_din, status
    );
endinterface

// File: rtl/rx_pkt_fifo_ctrl.sv
// Admits whole receive packets into the {eof,data} FIFO, dropping or truncating as needed.
// Latency: one cycle from an accepted input word to the FIFO write strobe and status update.
// No backpressure: words that cannot be stored are discarded and counted, never stalled.
module rx_pkt_fifo_ctrl #(
    parameter int FIFO_AW       = 9,
    parameter int MAX_PKT_WORDS = 128,
    parameter int MARGIN        = 2
) (
    input  logic                user_clk,
    input  logic                user_rst_n,
    rx_pkt_fifo_ctrl_if.slave   bus
);
    localparam int WCW = $clog2(MAX_PKT_WORDS + 1);

    // Full depth and admission threshold, both at the FIFO count width.
    localparam logic [FIFO_AW:0] DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] ADMIT_TH = (FIFO_AW+1)'(MAX_PKT_WORDS + MARGIN);
    // word_cnt value at which the incoming word is the last one we may store.
    localparam logic [WCW-1:0]   LAST_CNT = WCW'(MAX_PKT_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         r_state;
    logic [WCW-1:0] r_word_cnt;
    logic           r_wr_en;
    logic [64:0]    r_din;
    logic [5:0]     r_ovs_cnt;
    logic [7:0]     r_drop_cnt;
    logic [15:0]    r_pkt_cnt;

    logic [FIFO_AW:0] w_free;
    logic             w_admit;
    logic             w_last;
    logic             w_pkt_evt;
    logic             w_drop_evt;
    logic             w_ovs_evt;

    // Free space is only sampled on a packet's first word; MARGIN absorbs occupancy lag.
    assign w_free  = DEPTH - bus.fifo_count;
    assign w_admit = (w_free >= ADMIT_TH);
    assign w_last  = (r_word_cnt == LAST_CNT);

    // Decode the counter events for the current input word.
    always_comb begin
        w_pkt_evt  = 1'b0;
        w_drop_evt = 1'b0;
        w_ovs_evt  = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_admit) w_pkt_evt  = bus.in_eof;
                    else         w_drop_evt = 1'b1;
                end
                PASS: begin
                    if (bus.in_eof) begin
                        w_pkt_evt = 1'b1;
                    end else if (w_last) begin
                        w_pkt_evt = 1'b1;
                        w_ovs_evt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Packet FSM with registered FIFO write port; an in-packet eof always wins over truncation.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_din      <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (w_admit) begin
                            r_wr_en    <= 1'b1;
                            r_din      <= {bus.in_eof, bus.in_data};
                            r_word_cnt <= WCW'(1);
                            r_state    <= bus.in_eof ? IDLE : PASS;
                        end else begin
                            r_state    <= bus.in_eof ? IDLE : DROP;
                        end
                    end
                end
                PASS: begin
                    if (bus.in_valid) begin
                        r_wr_en    <= 1'b1;
                        r_word_cnt <= r_word_cnt + WCW'(1);
                        if (bus.in_eof) begin
                            r_din   <= {1'b1, bus.in_data};
                            r_state <= IDLE;
                        end else if (w_last) begin
                            // Truncate: close the stored packet and discard the tail.
                            r_din   <= {1'b1, bus.in_data};
                            r_state <= DROP;
                        end else begin
                            r_din   <= {1'b0, bus.in_data};
                        end
                    end
                end
                DROP: begin
                    if (bus.in_valid && bus.in_eof) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Status counters: clear has priority, so an event coinciding with it is lost.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
            r_ovs_cnt  <= '0;
        end else if (bus.cnt_clr) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
            r_ovs_cnt  <= '0;
        end else begin
            if (w_pkt_evt)                       r_pkt_cnt  <= r_pkt_cnt + 16'd1;
            if (w_drop_evt && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_ovs_evt && (r_ovs_cnt != '1))   r_ovs_cnt  <= r_ovs_cnt + 6'd1;
        end
    end

    assign bus.fifo_wr_en = r_wr_en;
    assign bus.fifo_din   = r_din;
    assign bus.status     = {r_state, r_ovs_cnt, r_drop_cnt, r_pkt_cnt};

endmodule

// File: tb/tb_rx_pkt_fifo_ctrl.sv
// Directed bench for rx_pkt_fifo_ctrl: admission, drop, truncation, saturation, reset, gaps.
// Inputs driven on the falling edge; outputs and FIFO writes sampled on the falling edge.
// The stream has no backpressure, so every wait is a fixed cycle count.
module tb_rx_pkt_fifo_ctrl;
    logic user_clk   = 1'b0;
    logic user_rst_n = 1'b0;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;

    logic [64:0] wq[$];
    int          cq[$];
    int          iq[$];

    rx_pkt_fifo_ctrl_if #(.FIFO_AW(9)) bus ();

    rx_pkt_fifo_ctrl #(
        .FIFO_AW(9),
        .MAX_PKT_WORDS(128),
        .MARGIN(2)
    ) dut (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .bus       (bus.slave)
    );

    always #5 user_clk = ~user_clk;

    always @(posedge user_clk) cyc <= cyc + 1;

    // Record every FIFO write and the cycle it was seen in.
    always @(negedge user_clk) begin
        if (bus.fifo_wr_en === 1'b1) begin
            wq.push_back(bus.fifo_din);
            cq.push_back(cyc);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] wq_at(input int i);
        if (i < wq.size()) return wq[i];
        return '1;
    endfunction

    task automatic clear_q();
        wq.delete();
        cq.delete();
        iq.delete();
    endtask

    task automatic do_reset();
        @(negedge user_clk);
        user_rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_eof   = 1'b0;
        bus.cnt_clr  = 1'b0;
        repeat (2) @(negedge user_clk);
        user_rst_n = 1'b1;
        @(negedge user_clk);
        clear_q();
    endtask

    // Send an n-word packet (data base, base+1, ...) with 'gap' idle cycles between words.
    // mid_st >= 0 checks the state seen after each non-final word.
    task automatic send_pkt(input int n, input logic [63:0] base, input int gap, input int mid_st);
        for (int i = 0; i < n; i++) begin
            @(negedge user_clk);
            if (i > 0 && mid_st >= 0) check("mid_state", 64'(bus.status[31:30]), 64'(mid_st));
            bus.in_valid = 1'b1;
            bus.in_data  = base + 64'(i);
            bus.in_eof   = (i == n - 1);
            iq.push_back(cyc);
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge user_clk);
                    bus.in_valid = 1'b0;
                    if (mid_st >= 0) check("gap_state", 64'(bus.status[31:30]), 64'(mid_st));
                end
            end
        end
        @(negedge user_clk);
        bus.in_valid = 1'b0;
        bus.in_eof   = 1'b0;
        repeat (2) @(negedge user_clk);
    endtask

    initial begin
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.in_eof     = 1'b0;
        bus.cnt_clr    = 1'b0;
        bus.fifo_count = '0;

        // Reset state
        repeat (2) @(negedge user_clk);
        check("rst_wr_en",  64'(bus.fifo_wr_en), 64'h0);
        check("rst_din",    64'(bus.fifo_din[63:0]), 64'h0);
        check("rst_status", 64'(bus.status), 64'h0);
        user_rst_n = 1'b1;
        @(negedge user_clk);
        clear_q();

        // 1: 4-word packet into an empty FIFO
        send_pkt(4, 64'd1, 0, 1);
        check("t1_nwr", 64'(wq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", 64'(wq_at(i)[63:0]), 64'(i + 1));
            check("t1_eof",  64'(wq_at(i)[64]), 64'(i == 3));
            if (i < cq.size()) check("t1_lat", 64'(cq[i] - iq[i]), 64'd1);
        end
        check("t1_status", 64'(bus.status), 64'h0000_0001);

        // 2: not enough room -> whole packet dropped; then exactly enough room
        do_reset();
        bus.fifo_count = 10'd384;
        send_pkt(10, 64'h100, 0, 2);
        check("t2_nwr",    64'(wq.size()), 64'd0);
        check("t2_status", 64'(bus.status), 64'h0001_0000);
        bus.fifo_count = 10'd382;
        send_pkt(1, 64'hABC, 0, -1);
        check("t2_nwr1",   64'(wq.size()), 64'd1);
        check("t2_word",   64'(wq_at(0)[63:0]), 64'hABC);
        check("t2_eof",    64'(wq_at(0)[64]), 64'd1);
        check("t2_status2", 64'(bus.status), 64'h0001_0001);

        // 3: oversize packet truncated at 128 words
        do_reset();
        bus.fifo_count = 10'd0;
        send_pkt(200, 64'd1, 0, -1);
        check("t3_nwr",    64'(wq.size()), 64'd128);
        check("t3_eof127", 64'(wq_at(126)[64]), 64'd0);
        check("t3_eof128", 64'(wq_at(127)[64]), 64'd1);
        check("t3_dat128", 64'(wq_at(127)[63:0]), 64'd128);
        check("t3_status", 64'(bus.status), 64'h0100_0001);

        // 4: drop counter saturation, then clear
        do_reset();
        bus.fifo_count = 10'd512;
        for (int i = 0; i < 300; i++) begin
            @(negedge user_clk);
            bus.in_valid = 1'b1;
            bus.in_eof   = 1'b1;
            bus.in_data  = 64'(i);
        end
        @(negedge user_clk);
        bus.in_valid = 1'b0;
        bus.in_eof   = 1'b0;
        @(negedge user_clk);
        check("t4_nwr",    64'(wq.size()), 64'd0);
        check("t4_status", 64'(bus.status), 64'h00FF_0000);
        bus.cnt_clr = 1'b1;
        @(negedge user_clk);
        bus.cnt_clr = 1'b0;
        @(negedge user_clk);
        check("t4_clr", 64'(bus.status), 64'h0);

        // 5: asynchronous reset in the middle of a packet
        do_reset();
        bus.fifo_count = 10'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge user_clk);
            bus.in_valid = 1'b1;
            bus.in_eof   = 1'b0;
            bus.in_data  = 64'(i + 7);
        end
        @(posedge user_clk);
        #2;
        check("t5_pre_wr",  64'(bus.fifo_wr_en), 64'd1);
        check("t5_pre_st",  64'(bus.status[31:30]), 64'd1);
        user_rst_n   = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("t5_rst_wr",  64'(bus.fifo_wr_en), 64'd0);
        check("t5_rst_st",  64'(bus.status), 64'h0);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        @(negedge user_clk);
        clear_q();
        send_pkt(2, 64'h10, 0, 1);
        check("t5_nwr",    64'(wq.size()), 64'd2);
        check("t5_w0",     64'(wq_at(0)), 64'(65'h0_0000_0000_0000_0010));
        check("t5_w1",     64'(wq_at(1)[63:0]), 64'h11);
        check("t5_eof1",   64'(wq_at(1)[64]), 64'd1);
        check("t5_eof0",   64'(wq_at(0)[64]), 64'd0);
        check("t5_status", 64'(bus.status), 64'h0000_0001);

        // 6: idle gaps inside a packet hold the PASS state
        do_reset();
        send_pkt(3, 64'h20, 5, 1);
        check("t6_nwr",    64'(wq.size()), 64'd3);
        check("t6_eof",    64'(wq_at(2)[64]), 64'd1);
        check("t6_dat",    64'(wq_at(2)[63:0]), 64'h22);
        check("t6_status", 64'(bus.status), 64'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
